// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: free-running counter plus glitch-free CPU clock source selector (fast tap, slow tap, divider, single step)
module clk_div_ctrl #(
    parameter int CNT_W    = 32,
    parameter int FAST_TAP = 2,
    parameter int SLOW_TAP = 24,
    parameter int DIV_W    = 16,
    parameter int HOLD_CYC = 2,
    parameter int STEP_HI  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_val,
    input  logic             step,
    output logic [CNT_W-1:0] clkdiv,
    output logic             Clk_CPU,
    output logic             cpu_rise,
    output logic             busy
);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int SW = $clog2(STEP_HI + 1);

    typedef enum logic [1:0] {RUN, PARK, HOLD} state_t;

    state_t           state_q, state_d;
    logic [1:0]       act_q, act_d;
    logic [CNT_W-1:0] clkdiv_q;
    logic             clk_q, clk_d, rise_q, busy_q, busy_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_lat_q, div_lat_d;
    logic [SW-1:0]    step_cnt_q, step_cnt_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [2:0]       sync_q;
    logic             step_ev, div_wrap, drive, src_clk;

    // sync_q[2] holds the previous synchronized level, so a 0->1 between [2] and [1] is one step event
    assign step_ev  = sync_q[1] & ~sync_q[2];
    assign div_wrap = div_cnt_q == div_lat_q;
    // the old source keeps running in PARK until its high phase has finished
    assign drive    = state_q == RUN || (state_q == PARK && clk_q);
    assign src_clk  = act_q == 2'b00 ? clkdiv_q[FAST_TAP] :
                      act_q == 2'b01 ? clkdiv_q[SLOW_TAP] :
                      act_q == 2'b10 ? clk_q ^ div_wrap :
                      step_cnt_q != '0 ? step_cnt_q != SW'(1) : step_ev;

    assign clkdiv   = clkdiv_q;
    assign Clk_CPU  = clk_q;
    assign cpu_rise = rise_q;
    assign busy     = busy_q;

    // next state: drive the active source, park it low, hold low, then adopt the requested mode
    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        clk_d      = 1'b0;
        busy_d     = busy_q;
        div_cnt_d  = div_cnt_q;
        div_lat_d  = div_lat_q;
        step_cnt_d = step_cnt_q;
        hold_d     = hold_q;
        if (drive) begin
            clk_d = src_clk;
            if (act_q == 2'b10) begin
                div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
                div_lat_d = div_wrap ? div_val : div_lat_q;
            end
            if (act_q == 2'b11)
                step_cnt_d = step_cnt_q != '0 ? step_cnt_q - 1'b1 : step_ev ? SW'(STEP_HI) : '0;
        end
        case (state_q)
            RUN: if (mode != act_q) begin
                busy_d  = 1'b1;
                state_d = PARK;
            end
            PARK: if (!clk_q) begin
                hold_d  = HW'(HOLD_CYC);
                state_d = HOLD;
            end
            HOLD: begin
                hold_d = hold_q - 1'b1;
                if (hold_q == HW'(1)) begin
                    state_d    = RUN;
                    act_d      = mode;
                    div_cnt_d  = '0;
                    div_lat_d  = div_val;
                    step_cnt_d = '0;
                    busy_d     = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // state registers; reset aborts any switch or step pulse immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            act_q      <= 2'b00;
            clkdiv_q   <= '0;
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
            busy_q     <= 1'b0;
            div_cnt_q  <= '0;
            div_lat_q  <= '0;
            step_cnt_q <= '0;
            hold_q     <= '0;
            sync_q     <= '0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            clkdiv_q   <= clkdiv_q + 1'b1;
            clk_q      <= clk_d;
            rise_q     <= clk_d & ~clk_q;
            busy_q     <= busy_d;
            div_cnt_q  <= div_cnt_d;
            div_lat_q  <= div_lat_d;
            step_cnt_q <= step_cnt_d;
            hold_q     <= hold_d;
            sync_q     <= {sync_q[1:0], step};
        end
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench for clk_div_ctrl, full-width and 8-bit-counter instances against a behavioural model
module tb_clk_div_ctrl;
    logic        clk, rst, step;
    logic [1:0]  mode0, mode1;
    logic [15:0] div_val;
    logic [31:0] cd0;
    logic [7:0]  cd1;
    logic        ck0, ck1, rs0, rs1, bz0, bz1;
    int total = 0, bad = 0;

    typedef struct packed {
        logic [31:0] cd;
        logic        ck;
        logic        rise;
        logic        bsy;
    } exp_t;
    exp_t q0[$], q1[$];

    // model state per instance: ph 0 running, 1 waiting for low, 2 forced low
    logic [31:0] m_cnt[2];
    logic        m_ck[2], m_rise[2], m_bsy[2], h1[2], h2[2], h3[2];
    int          m_ph[2], m_act[2], m_rem[2], m_hi[2], m_hl[2];

    clk_div_ctrl u0 (.clk(clk), .rst(rst), .mode(mode0), .div_val(div_val), .step(step),
                     .clkdiv(cd0), .Clk_CPU(ck0), .cpu_rise(rs0), .busy(bz0));
    clk_div_ctrl #(.CNT_W(8), .SLOW_TAP(7)) u1 (.clk(clk), .rst(rst), .mode(mode1), .div_val(div_val),
                     .step(step), .clkdiv(cd1), .Clk_CPU(ck1), .cpu_rise(rs1), .busy(bz1));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic mreset(input int k);
        m_cnt[k] = 0; m_ck[k] = 0; m_rise[k] = 0; m_bsy[k] = 0;
        h1[k] = 0; h2[k] = 0; h3[k] = 0;
        m_ph[k] = 0; m_act[k] = 0; m_rem[k] = 0; m_hi[k] = 0; m_hl[k] = 0;
    endtask

    task automatic mtick(input int k, input logic [1:0] md);
        logic [31:0] oc;
        logic        ev, nck, oldck;
        int          slow;
        oc = m_cnt[k];
        oldck = m_ck[k];
        slow = k == 0 ? 24 : 7;
        ev = h2[k] && !h3[k];
        h3[k] = h2[k]; h2[k] = h1[k]; h1[k] = step;
        m_cnt[k] = k == 0 ? oc + 1 : (oc + 1) & 32'hFF;
        nck = 0;
        if (m_ph[k] == 0 || (m_ph[k] == 1 && oldck)) begin
            case (m_act[k])
                0: nck = oc[2];
                1: nck = oc[slow];
                2: if (m_rem[k] == 0) begin
                    nck = !oldck;
                    m_rem[k] = int'(div_val);
                end else begin
                    nck = oldck;
                    m_rem[k]--;
                end
                default: if (m_hi[k] > 0) begin
                    m_hi[k]--;
                    nck = m_hi[k] > 0;
                end else if (ev) begin
                    m_hi[k] = 4;
                    nck = 1;
                end
            endcase
        end
        if (m_ph[k] == 0 && int'(md) != m_act[k]) begin
            m_ph[k] = 1;
            m_bsy[k] = 1;
        end else if (m_ph[k] == 1 && !oldck) begin
            m_ph[k] = 2;
            m_hl[k] = 2;
        end else if (m_ph[k] == 2) begin
            m_hl[k]--;
            if (m_hl[k] == 0) begin
                m_ph[k] = 0;
                m_act[k] = int'(md);
                m_rem[k] = int'(div_val);
                m_hi[k] = 0;
                m_bsy[k] = 0;
            end
        end
        m_rise[k] = nck && !oldck;
        m_ck[k] = nck;
    endtask

    // reference model: one step per clock edge, expectations queued for the monitor
    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) mreset(k);
                else mtick(k, k == 0 ? mode0 : mode1);
                if (k == 0) q0.push_back({m_cnt[k], m_ck[k], m_rise[k], m_bsy[k]});
                else q1.push_back({m_cnt[k], m_ck[k], m_rise[k], m_bsy[k]});
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    // monitor: compare DUT outputs just after each edge against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() == 0 || q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL queue_empty got=%0d/%0d want=nonzero", q0.size(), q1.size());
            end else begin
                e = q0.pop_front();
                cmp("u0_clkdiv", cd0, e.cd);
                cmp("u0_clk_cpu", 32'(ck0), 32'(e.ck));
                cmp("u0_cpu_rise", 32'(rs0), 32'(e.rise));
                cmp("u0_busy", 32'(bz0), 32'(e.bsy));
                e = q1.pop_front();
                cmp("u1_clkdiv", 32'(cd1), e.cd);
                cmp("u1_clk_cpu", 32'(ck1), 32'(e.ck));
                cmp("u1_cpu_rise", 32'(rs1), 32'(e.rise));
                cmp("u1_busy", 32'(bz1), 32'(e.bsy));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_model(input int ph, input int act, input int lim);
        int n = 0;
        while (!(m_ph[0] == ph && (act < 0 || m_act[0] == act)) && n < lim) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(m_ph[0] == ph && (act < 0 || m_act[0] == act))) begin
            bad++;
            $display("FAIL wait_timeout got=ph%0d/act%0d want=ph%0d/act%0d", m_ph[0], m_act[0], ph, act);
        end
    endtask

    // async reset between edges must clear the outputs before the next edge
    task automatic rst_now();
        rst = 1;
        #1;
        cmp("rst_u0_clkdiv", cd0, 0);
        cmp("rst_u0_clk_cpu", 32'(ck0), 0);
        cmp("rst_u0_cpu_rise", 32'(rs0), 0);
        cmp("rst_u0_busy", 32'(bz0), 0);
        cmp("rst_u1_clk_cpu", 32'(ck1), 0);
        step = 0;
        mode0 = 0;
        cyc(2);
        rst = 0;
    endtask

    initial begin
        rst = 1; step = 0; mode0 = 0; mode1 = 0; div_val = 0;
        cyc(3);
        rst = 0;
        mode1 = 1;
        cyc(64);
        mode0 = 2; div_val = 3;
        cyc(40);
        div_val = 0;
        cyc(20);
        mode0 = 3;
        wait_model(0, 3, 40);
        step = 1; cyc(2); step = 0; cyc(2);
        step = 1; cyc(1); step = 0; cyc(10);
        step = 1; cyc(1); step = 0; cyc(10);
        div_val = 9; mode0 = 2;
        wait_model(0, 2, 40);
        cyc(14);
        mode0 = 0;
        cyc(40);
        mode0 = 2;
        wait_model(2, -1, 60);
        rst_now();
        cyc(30);
        mode0 = 3;
        wait_model(0, 3, 40);
        step = 1;
        for (int n = 0; n < 10 && !m_ck[0]; n++) @(negedge clk);
        cmp("step_pulse_started", 32'(m_ck[0]), 1);
        cyc(1);
        rst_now();
        cyc(30);
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 39) == 0) mode0 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) div_val = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0) step = ~step;
            cyc(1);
        end
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
